// File: rtl/rf_iu_pkg.sv
// Shared RF/IU generator package: address-width helper and init-sequencer state encoding.
package rf_iu_pkg;

  // Ceiling log2; number of address bits needed to index 'value' entries.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_iu_state_e;

endpackage

// File: rtl/rf_init_sequencer.sv
// RF init sequencer: sweeps every RF entry with the init value after reset or on
// start_in, stalling the core via glockreq_out; passes writes through when idle.
// Build option: define RF_INIT_PATTERN_EN to write entry index k into entry k
// instead of zero.
module rf_init_sequencer
  import rf_iu_pkg::*;
#(
  parameter int unsigned data_width_g = 32,
  parameter int unsigned depth_g      = 32
) (
  input  logic                        clk,
  input  logic                        rstx,
  input  logic                        glock_in,
  input  logic                        wload_in,
  input  logic [clogb2(depth_g)-1:0]  wop_in,
  input  logic [data_width_g-1:0]     wdata_in,
  input  logic                        start_in,
  output logic                        glock_out,
  output logic                        wload_out,
  output logic [clogb2(depth_g)-1:0]  wop_out,
  output logic [data_width_g-1:0]     wdata_out,
  output logic                        glockreq_out,
  output logic                        busy_out,
  output logic                        done_out
);

  localparam int unsigned AW = clogb2(depth_g);
  localparam int unsigned DW = data_width_g;
  localparam logic [AW-1:0] LAST_ADDR = AW'(depth_g - 1);

  rf_iu_state_e   st_q, st_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [DW-1:0]  init_data;

  // Value written into the entry currently addressed by the sweep.
`ifdef RF_INIT_PATTERN_EN
  assign init_data = DW'(cnt_q);
`else
  assign init_data = '0;
`endif

  // State, sweep counter and done pulse registers.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      st_q   <= ST_CLEAR;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Next-state logic and RF port muxing (passthrough when idle, sweep when clearing).
  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    glock_out    = glock_in;
    wload_out    = wload_in;
    wop_out      = wop_in;
    wdata_out    = wdata_in;
    glockreq_out = 1'b0;
    busy_out     = 1'b0;
    done_out     = done_q;

    unique case (st_q)
      ST_CLEAR: begin
        // Core writes are dropped; glock is forced low so the RF takes the sweep.
        glock_out    = 1'b0;
        wload_out    = 1'b1;
        wop_out      = cnt_q;
        wdata_out    = init_data;
        glockreq_out = 1'b1;
        busy_out     = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          st_d   = ST_IDLE;
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        if (start_in) begin
          st_d  = ST_CLEAR;
          cnt_d = '0;
        end
      end
    endcase
  end

endmodule
